// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage core: forwarding, load-use/scoreboard stalls, branch flush,
// and a single long-latency unit tracker. Optional perf counters under HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = $clog2(NREG),
  parameter int unsigned MAX_LAT = 16,
  parameter int unsigned LW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] RdD,
  input  logic          LongOpD,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic          LoadE,
  input  logic          LongIssueE,
  input  logic [LW-1:0] LongLatE,
  input  logic          PCSrcE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  output logic [1:0]    forwardAE,
  output logic [1:0]    forwardBE,
  output logic          stallF,
  output logic          stallD,
  output logic          flushD,
  output logic          flushE,
  output logic          LongWbV,
  output logic [AW-1:0] LongWbRd,
  output logic          LongBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   PerfStallCnt,
  output logic [31:0]   PerfFlushCnt,
  output logic [31:0]   PerfLongCnt
`endif
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {IDLE, RUN} longStateT;

  longStateT       state, stateNext;
  logic [LW-1:0]   cnt, cntNext;
  logic            wbVNext;
  logic [AW-1:0]   wbRdNext;
  logic [NREG-1:0] busy, busyNext;
  logic            setBusy, clrBusy, acceptIssue;
  logic [LW-1:0]   latClamped;
  logic            lwStall, sbStall, issueHit, stall;

  // Forwarding selects; Memory stage wins over Writeback
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (RegWriteM && (Rs1E == RdM) && (Rs1E != '0))      forwardAE = FWD_MEM;
    else if (RegWriteW && (Rs1E == RdW) && (Rs1E != '0)) forwardAE = FWD_WB;
    if (RegWriteM && (Rs2E == RdM) && (Rs2E != '0))      forwardBE = FWD_MEM;
    else if (RegWriteW && (Rs2E == RdW) && (Rs2E != '0)) forwardBE = FWD_WB;
  end

  // Stall and flush generation; a taken branch overrides any D-stage stall
  always_comb begin
    lwStall  = LoadE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
    issueHit = LongIssueE && (RdE != '0) &&
               ((RdE == Rs1D) || (RdE == Rs2D) || (RdE == RdD));
    sbStall  = busy[Rs1D] || busy[Rs2D] || busy[RdD] || issueHit ||
               (LongOpD && (LongBusy || LongIssueE));
    stall    = lwStall || sbStall;
    stallF   = stall && !PCSrcE;
    stallD   = stall && !PCSrcE;
    flushE   = stall || PCSrcE;
    flushD   = PCSrcE;
  end

  // Latency clamped into [2, MAX_LAT] so the counter always sees at least one RUN step
  always_comb begin
    latClamped = LongLatE;
    if (LongLatE < LW'(2))            latClamped = LW'(2);
    else if (LongLatE > LW'(MAX_LAT)) latClamped = LW'(MAX_LAT);
  end

  assign LongBusy = (state == RUN);

  // Long-unit next state; writeback is a registered one-cycle pulse
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    wbVNext     = 1'b0;
    wbRdNext    = LongWbRd;
    setBusy     = 1'b0;
    clrBusy     = 1'b0;
    acceptIssue = 1'b0;
    case (state)
      IDLE: begin
        if (LongIssueE) begin
          stateNext   = RUN;
          cntNext     = latClamped - LW'(1);
          wbRdNext    = RdE;
          setBusy     = (RdE != '0);
          acceptIssue = 1'b1;
        end
      end
      RUN: begin
        if (LongWbV) begin
          stateNext = IDLE;
          clrBusy   = 1'b1;
        end else begin
          cntNext = cnt - LW'(1);
          if (cnt == LW'(1)) wbVNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busyNext = busy;
    if (setBusy) busyNext[RdE] = 1'b1;
    if (clrBusy) busyNext[LongWbRd] = 1'b0;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      LongWbV  <= 1'b0;
      LongWbRd <= '0;
      busy     <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      LongWbV  <= wbVNext;
      LongWbRd <= wbRdNext;
      busy     <= busyNext;
    end
  end

`ifdef HAZARD_PERF_EN
  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      PerfStallCnt <= '0;
      PerfFlushCnt <= '0;
      PerfLongCnt  <= '0;
    end else begin
      if (stallD)      PerfStallCnt <= PerfStallCnt + 32'd1;
      if (PCSrcE)      PerfFlushCnt <= PerfFlushCnt + 32'd1;
      if (acceptIssue) PerfLongCnt  <= PerfLongCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random traffic,
// all checked against a cycle-indexed reference model of the long unit and hazard rules.
module tb_hazard_scoreboard;

  localparam int unsigned NREG    = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned MAX_LAT = 16;
  localparam int unsigned LW      = 5;

  logic          clk, reset;
  logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          LongOpD, LoadE, LongIssueE, PCSrcE, RegWriteM, RegWriteW;
  logic [LW-1:0] LongLatE;
  logic [1:0]    forwardAE, forwardBE;
  logic          stallF, stallD, flushD, flushE, LongWbV, LongBusy;
  logic [AW-1:0] LongWbRd;
`ifdef HAZARD_PERF_EN
  logic [31:0]   PerfStallCnt, PerfFlushCnt, PerfLongCnt;
  logic [31:0]   mStallCnt, mFlushCnt, mLongCnt;
`endif

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAX_LAT(MAX_LAT), .LW(LW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongOpD(LongOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE),
    .LongIssueE(LongIssueE), .LongLatE(LongLatE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .LongWbV(LongWbV), .LongWbRd(LongWbRd), .LongBusy(LongBusy)
`ifdef HAZARD_PERF_EN
    , .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt), .PerfLongCnt(PerfLongCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  // Reference model: the last accepted long op, described by issue cycle, latency and target
  int cyc      = 0;
  bit mActive  = 1'b0;
  int issueCyc = 0;
  int mLat     = 0;
  int mRd      = 0;
  int mWbRd    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  function automatic int clampLat(input int l);
    if (l < 2) return 2;
    if (l > int'(MAX_LAT)) return int'(MAX_LAT);
    return l;
  endfunction

  // Unit occupied from the cycle after issue through the writeback cycle
  function automatic bit unitBusy();
    return mActive && (cyc <= issueCyc + mLat);
  endfunction

  function automatic bit regBusy(input int r);
    return unitBusy() && (r == mRd) && (r != 0);
  endfunction

  function automatic int fwdExp(input int rs);
    if (RegWriteM && rs == int'(RdM) && rs != 0) return 2;
    if (RegWriteW && rs == int'(RdW) && rs != 0) return 1;
    return 0;
  endfunction

  function automatic bit stallExp();
    int s1, s2, d, e;
    bit lw, sb;
    s1 = int'(Rs1D); s2 = int'(Rs2D); d = int'(RdD); e = int'(RdE);
    lw = LoadE && e != 0 && (s1 == e || s2 == e);
    sb = regBusy(s1) || regBusy(s2) || regBusy(d) ||
         (LongIssueE && e != 0 && (e == s1 || e == s2 || e == d)) ||
         (LongOpD && (unitBusy() || LongIssueE));
    return lw || sb;
  endfunction

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; RdD = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    LongOpD = 1'b0; LoadE = 1'b0; LongIssueE = 1'b0; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LongLatE = '0;
  endtask

  // Move to mid-cycle and compare every output with the model
  task automatic settle();
    bit st;
    #4;
    st = stallExp();
    check("forwardAE", 32'(forwardAE), 32'(fwdExp(int'(Rs1E))));
    check("forwardBE", 32'(forwardBE), 32'(fwdExp(int'(Rs2E))));
    check("stallF",    32'(stallF),    32'(st && !PCSrcE));
    check("stallD",    32'(stallD),    32'(st && !PCSrcE));
    check("flushD",    32'(flushD),    32'(PCSrcE));
    check("flushE",    32'(flushE),    32'(st || PCSrcE));
    check("LongBusy",  32'(LongBusy),  32'(unitBusy()));
    check("LongWbV",   32'(LongWbV),   32'(unitBusy() && cyc == issueCyc + mLat));
    check("LongWbRd",  32'(LongWbRd),  32'(mWbRd));
`ifdef HAZARD_PERF_EN
    check("PerfStallCnt", PerfStallCnt, mStallCnt);
    check("PerfFlushCnt", PerfFlushCnt, mFlushCnt);
    check("PerfLongCnt",  PerfLongCnt,  mLongCnt);
`endif
  endtask

  // Clock edge: advance the model with the inputs the DUT just sampled
  task automatic advance();
    bit st;
    @(posedge clk);
    st = stallExp();
    if (!reset) begin
      mActive = 1'b0;
      mWbRd   = 0;
`ifdef HAZARD_PERF_EN
      mStallCnt = '0; mFlushCnt = '0; mLongCnt = '0;
`endif
    end else begin
`ifdef HAZARD_PERF_EN
      if (st && !PCSrcE) mStallCnt = mStallCnt + 32'd1;
      if (PCSrcE)        mFlushCnt = mFlushCnt + 32'd1;
`endif
      if (LongIssueE && !unitBusy()) begin
        mActive  = 1'b1;
        issueCyc = cyc;
        mLat     = clampLat(int'(LongLatE));
        mRd      = int'(RdE);
        mWbRd    = int'(RdE);
`ifdef HAZARD_PERF_EN
        mLongCnt = mLongCnt + 32'd1;
`endif
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      advance();
    end
  endtask

  initial begin
    clearInputs();
    reset = 1'b0;
    advance();
    advance();
    #4;
    check("rst_LongWbV",  32'(LongWbV),  32'd0);
    check("rst_LongWbRd", 32'(LongWbRd), 32'd0);
    check("rst_LongBusy", 32'(LongBusy), 32'd0);
    #1;
    reset = 1'b1;
    advance();

    // Forwarding priority and x0 exclusion
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5;
    settle();
    check("t1_fwdA_mem", 32'(forwardAE), 32'd2);
    advance();
    RegWriteM = 1'b0; Rs2E = 5'd5;
    settle();
    check("t1_fwdA_wb", 32'(forwardAE), 32'd1);
    check("t1_fwdB_wb", 32'(forwardBE), 32'd1);
    advance();
    RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0;
    settle();
    check("t1_fwdA_x0", 32'(forwardAE), 32'd0);
    advance();
    clearInputs();

    // Load-use stall
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    settle();
    check("t2_stallF", 32'(stallF), 32'd1);
    check("t2_flushE", 32'(flushE), 32'd1);
    check("t2_flushD", 32'(flushD), 32'd0);
    advance();
    LoadE = 1'b0;
    settle();
    check("t2_clear", 32'({stallF, stallD, flushD, flushE}), 32'd0);
    advance();
    clearInputs();

    // Long op latency 4 with a dependent instruction held in Decode
    LongIssueE = 1'b1; RdE = 5'd9; LongLatE = 5'd4; Rs1D = 5'd9;
    settle();
    check("t3_stall_c0", 32'(stallD), 32'd1);
    advance();
    LongIssueE = 1'b0; RdE = 5'd0;
    for (int i = 1; i <= 6; i++) begin
      settle();
      check("t3_stallD", 32'(stallD), 32'(i <= 4));
      check("t3_wbv", 32'(LongWbV), 32'(i == 4));
      if (i == 4) check("t3_wbrd", 32'(LongWbRd), 32'd9);
      advance();
    end
    clearInputs();

    // Latency clamping at both ends
    LongIssueE = 1'b1; RdE = 5'd3; LongLatE = 5'd0;
    settle();
    advance();
    LongIssueE = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      check("t4_wbv_min", 32'(LongWbV), 32'(i == 2));
      advance();
    end
    LongIssueE = 1'b1; RdE = 5'd4; LongLatE = 5'd31;
    settle();
    advance();
    LongIssueE = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      settle();
      check("t4_wbv_max", 32'(LongWbV), 32'(i == 16));
      advance();
    end
    clearInputs();

    // Taken branch overrides a structural stall
    LongIssueE = 1'b1; RdE = 5'd11; LongLatE = 5'd8;
    settle();
    advance();
    clearInputs();
    LongOpD = 1'b1; PCSrcE = 1'b1;
    settle();
    check("t5_stallD", 32'(stallD), 32'd0);
    check("t5_flushD", 32'(flushD), 32'd1);
    check("t5_flushE", 32'(flushE), 32'd1);
    advance();
    clearInputs();
    idleCycles(9);

    // Reset while busy drops the in-flight op
    LongIssueE = 1'b1; RdE = 5'd9; LongLatE = 5'd10; Rs1D = 5'd9;
    settle();
    advance();
    LongIssueE = 1'b0; RdE = 5'd0;
    idleCycles(2);
    reset = 1'b0;
    settle();
    advance();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      settle();
      check("t6_wbv", 32'(LongWbV), 32'd0);
      check("t6_stallD", 32'(stallD), 32'd0);
      advance();
    end

    // Random traffic on a small register window to provoke collisions
    for (int i = 0; i < 600; i++) begin
      Rs1D = AW'($urandom_range(0, 7)); Rs2D = AW'($urandom_range(0, 7));
      RdD  = AW'($urandom_range(0, 7)); Rs1E = AW'($urandom_range(0, 7));
      Rs2E = AW'($urandom_range(0, 7)); RdE  = AW'($urandom_range(0, 7));
      RdM  = AW'($urandom_range(0, 7)); RdW  = AW'($urandom_range(0, 7));
      LongOpD    = ($urandom_range(0, 3) == 0);
      LoadE      = ($urandom_range(0, 3) == 0);
      LongIssueE = ($urandom_range(0, 4) == 0);
      PCSrcE     = ($urandom_range(0, 5) == 0);
      RegWriteM  = $urandom_range(0, 1) != 0;
      RegWriteW  = $urandom_range(0, 1) != 0;
      LongLatE   = LW'($urandom_range(0, 31));
      reset      = ($urandom_range(0, 63) != 0);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
